// File: rtl/ps2_keyboard.sv
`timescale 1ns/1ps
// PS/2 scan-code set 2 receiver: conditions the raw lines, deframes bytes and
// tracks the Hack keycode of the key currently held.
module ps2_keyboard #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       key_event,
   output logic       frame_error
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic          clk_filt_q, clk_filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          byte_valid, frame_err;

   logic          ext_q, ext_d, brk_q, brk_d;
   logic [7:0]    keycode_q, keycode_d, xlate;
   logic          key_event_q, frame_error_q;

   // The filtered level only follows the synchronized clock after FILTER_LEN
   // consecutive samples disagree with it; any agreeing sample restarts the count.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      clk_filt_d = clk_filt_q;
      filt_cnt_d = '0;
      fall       = 1'b0;
      if (clk_sync_q != clk_filt_q) begin
         if (filt_cnt_q == FILT_MAX) begin
            clk_filt_d = clk_sync_q;
            fall       = clk_filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      to_cnt_d   = '0;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (state_q)
         S_IDLE: if (fall) begin
            if (!data_sync_q) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end else begin
               frame_err = 1'b1;
            end
         end
         S_DATA: if (fall) begin
            shift_d   = {data_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = S_PARITY;
         end
         S_PARITY: if (fall) begin
            parity_d = data_sync_q;
            state_d  = S_STOP;
         end
         S_STOP: if (fall) begin
            state_d = S_IDLE;
            if (data_sync_q && (^shift_q ^ parity_q)) byte_valid = 1'b1;
            else                                     frame_err  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // A stalled keyboard mid-frame must not wedge the deframer.
      if (state_q != S_IDLE && !fall) begin
         if (to_cnt_q == TO_MAX) begin
            state_d   = S_IDLE;
            frame_err = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      xlate = '0;
      case ({ext_q, shift_q})
         9'h01C: xlate = 8'd65;   9'h032: xlate = 8'd66;   9'h021: xlate = 8'd67;
         9'h023: xlate = 8'd68;   9'h024: xlate = 8'd69;   9'h02B: xlate = 8'd70;
         9'h034: xlate = 8'd71;   9'h033: xlate = 8'd72;   9'h043: xlate = 8'd73;
         9'h03B: xlate = 8'd74;   9'h042: xlate = 8'd75;   9'h04B: xlate = 8'd76;
         9'h03A: xlate = 8'd77;   9'h031: xlate = 8'd78;   9'h044: xlate = 8'd79;
         9'h04D: xlate = 8'd80;   9'h015: xlate = 8'd81;   9'h02D: xlate = 8'd82;
         9'h01B: xlate = 8'd83;   9'h02C: xlate = 8'd84;   9'h03C: xlate = 8'd85;
         9'h02A: xlate = 8'd86;   9'h01D: xlate = 8'd87;   9'h022: xlate = 8'd88;
         9'h035: xlate = 8'd89;   9'h01A: xlate = 8'd90;
         9'h045: xlate = 8'd48;   9'h016: xlate = 8'd49;   9'h01E: xlate = 8'd50;
         9'h026: xlate = 8'd51;   9'h025: xlate = 8'd52;   9'h02E: xlate = 8'd53;
         9'h036: xlate = 8'd54;   9'h03D: xlate = 8'd55;   9'h03E: xlate = 8'd56;
         9'h046: xlate = 8'd57;
         9'h029: xlate = 8'd32;   9'h05A: xlate = 8'd128;  9'h066: xlate = 8'd129;
         9'h076: xlate = 8'd140;
         9'h005: xlate = 8'd141;  9'h006: xlate = 8'd142;  9'h004: xlate = 8'd143;
         9'h00C: xlate = 8'd144;  9'h003: xlate = 8'd145;  9'h00B: xlate = 8'd146;
         9'h083: xlate = 8'd147;  9'h00A: xlate = 8'd148;  9'h001: xlate = 8'd149;
         9'h009: xlate = 8'd150;  9'h078: xlate = 8'd151;  9'h007: xlate = 8'd152;
         9'h16B: xlate = 8'd130;  9'h175: xlate = 8'd131;  9'h174: xlate = 8'd132;
         9'h172: xlate = 8'd133;  9'h16C: xlate = 8'd134;  9'h169: xlate = 8'd135;
         9'h17D: xlate = 8'd136;  9'h17A: xlate = 8'd137;  9'h170: xlate = 8'd138;
         9'h171: xlate = 8'd139;
         default: ;
      endcase
   end

   // A break only releases the key it names, so stray or unmapped breaks are inert.
   always_comb begin
      ext_d     = ext_q;
      brk_d     = brk_q;
      keycode_d = keycode_q;
      if (byte_valid) begin
         if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (xlate != 8'd0) begin
               if (!brk_q)                 keycode_d = xlate;
               else if (xlate == keycode_q) keycode_d = 8'd0;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta_q    <= 1'b1;
         clk_sync_q    <= 1'b1;
         data_meta_q   <= 1'b1;
         data_sync_q   <= 1'b1;
         clk_filt_q    <= 1'b1;
         filt_cnt_q    <= '0;
         state_q       <= S_IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         parity_q      <= 1'b0;
         to_cnt_q      <= '0;
         ext_q         <= 1'b0;
         brk_q         <= 1'b0;
         keycode_q     <= '0;
         key_event_q   <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         clk_meta_q    <= ps2_clk;
         clk_sync_q    <= clk_meta_q;
         data_meta_q   <= ps2_data;
         data_sync_q   <= data_meta_q;
         clk_filt_q    <= clk_filt_d;
         filt_cnt_q    <= filt_cnt_d;
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         parity_q      <= parity_d;
         to_cnt_q      <= to_cnt_d;
         ext_q         <= ext_d;
         brk_q         <= brk_d;
         keycode_q     <= keycode_d;
         key_event_q   <= (keycode_d != keycode_q);
         frame_error_q <= frame_err;
      end
   end

   assign keycode     = keycode_q;
   assign key_event   = key_event_q;
   assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
// Drives PS/2 frames into ps2_keyboard and compares keycode, key_event and
// frame_error against a table-driven model of the keyboard protocol.
module tb_ps2_keyboard;

   localparam int FILTER_LEN = 8;
   localparam int TO         = 300;
   localparam int HALF       = 20;
   localparam int LAT        = 2 + FILTER_LEN;

   logic       clk, reset, ps2_clk, ps2_data;
   logic [7:0] keycode;
   logic       key_event, frame_error;

   ps2_keyboard #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keycode(keycode), .key_event(key_event), .frame_error(frame_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0, ev_cnt = 0, err_cnt = 0, last_fall = 0;
   int n_vec = 0, n_err = 0;
   int m_key = 0, m_ev = 0, m_err = 0;
   bit m_ext = 0, m_brk = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (key_event === 1'b1)   ev_cnt++;
      if (frame_error === 1'b1) err_cnt++;
   end

   logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] fkey_sc  [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
                                  8'h09, 8'h78, 8'h07};
   logic [7:0] spec_sc  [4]  = '{8'h29, 8'h5A, 8'h66, 8'h76};
   int         spec_kc  [4]  = '{32, 128, 129, 140};
   logic [7:0] ext_sc   [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};

   function automatic int xlate(input bit ext, input logic [7:0] b);
      if (ext) begin
         for (int i = 0; i < 10; i++) if (ext_sc[i] == b) return 130 + i;
         return 0;
      end
      for (int i = 0; i < 26; i++) if (letter_sc[i] == b) return 65 + i;
      for (int i = 0; i < 10; i++) if (digit_sc[i] == b)  return 48 + i;
      for (int i = 0; i < 12; i++) if (fkey_sc[i] == b)   return 141 + i;
      for (int i = 0; i < 4; i++)  if (spec_sc[i] == b)   return spec_kc[i];
      return 0;
   endfunction

   task automatic pick_key(input int k, output bit ext, output logic [7:0] code);
      ext = 1'b0;
      if (k < 26)      code = letter_sc[k];
      else if (k < 36) code = digit_sc[k - 26];
      else if (k < 48) code = fkey_sc[k - 36];
      else if (k < 52) code = spec_sc[k - 48];
      else begin
         code = ext_sc[k - 52];
         ext  = 1'b1;
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      int t;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         t = xlate(m_ext, b);
         if (t != 0) begin
            if (!m_brk) begin
               if (t != m_key) begin
                  m_key = t;
                  m_ev++;
               end
            end else if (t == m_key) begin
               m_key = 0;
               m_ev++;
            end
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         tick(11);
         ps2_clk = 1'b0;
         tick(3);
         ps2_clk = 1'b1;
         tick(HALF - 14);
      end else begin
         tick(HALF);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      tick(HALF);
      ps2_clk   = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit glitch, input bit lat_chk,
                             input logic [7:0] lat_old, input logic [7:0] lat_new);
      ps2_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
      ps2_bit((~^b) ^ bad_par, glitch);
      ps2_data = ~bad_stop;
      tick(HALF);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      if (lat_chk) begin
         while (cyc < last_fall + LAT - 1) @(negedge clk);
         check("latency_before", keycode, lat_old);
         @(negedge clk);
         check("latency_after", keycode, lat_new);
         check("latency_event", key_event, 1);
         tick(HALF - LAT);
      end else begin
         tick(HALF);
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(HALF);
   endtask

   task automatic post_check(input logic [7:0] b);
      check($sformatf("keycode_after_%h", b), keycode, m_key);
      check($sformatf("events_after_%h", b), ev_cnt, m_ev);
      check($sformatf("errors_after_%h", b), err_cnt, m_err);
   endtask

   task automatic frame(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      model_byte(b);
      post_check(b);
   endtask

   task automatic bad_frame(input logic [7:0] b, input bit bad_par);
      send_frame(b, bad_par, ~bad_par, 1'b0, 1'b0, 8'd0, 8'd0);
      m_err++;
      post_check(b);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1);
   end

   initial begin
      int         r, k, last_k, tf;
      bit         e, brk, bp;
      logic [7:0] code;

      reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      tick(5);
      reset = 1'b0;
      tick(5);
      check("reset_keycode", keycode, 0);
      check("reset_key_event", key_event, 0);
      check("reset_frame_error", frame_error, 0);

      // Make, exact latency from the stop-bit fall.
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd65);
      model_byte(8'h1C);
      post_check(8'h1C);
      frame(8'h1C);                                    // repeat make: no event
      frame(8'hF0); frame(8'h1C);                      // release -> 0
      frame(8'h1C); frame(8'hF0); frame(8'h32);        // foreign break ignored
      frame(8'hF0); frame(8'h1C);

      // Extended keys, unmapped plain 75, and F0 before E0.
      frame(8'hE0); frame(8'h75);
      frame(8'h75);
      frame(8'hE0); frame(8'hF0); frame(8'h75);
      frame(8'hE0); frame(8'h75);
      frame(8'hF0); frame(8'hE0); frame(8'h75);

      // Parity and stop errors, then a prefix surviving an error frame.
      bad_frame(8'h1C, 1'b1);
      bad_frame(8'h1C, 1'b0);
      frame(8'hE0); bad_frame(8'h44, 1'b1); frame(8'h75);
      frame(8'hE0); frame(8'hF0); frame(8'h75);
      frame(8'h29);

      // Bad start bit: a single fall with data high.
      ps2_data = 1'b1;
      tick(HALF); ps2_clk = 1'b0; tick(HALF); ps2_clk = 1'b1; tick(HALF);
      m_err++;
      check("bad_start_errors", err_cnt, m_err);

      // Timeout after four data bits.
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
      ps2_data = 1'b1;
      tf = last_fall;
      while (cyc < tf + LAT + TO - 1) @(negedge clk);
      check("timeout_early", frame_error, 0);
      @(negedge clk);
      check("timeout_fire", frame_error, 1);
      m_err++;
      tick(HALF);
      check("timeout_errors", err_cnt, m_err);
      frame(8'h5A);

      // Glitches on the clock line, idle and mid-frame.
      for (int i = 0; i < 3; i++) begin
         ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(10);
      end
      check("glitch_idle_errors", err_cnt, m_err);
      send_frame(8'h32, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      model_byte(8'h32);
      post_check(8'h32);

      // Reset in the middle of a frame.
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
      reset = 1'b1;
      tick(2);
      check("midreset_keycode", keycode, 0);
      check("midreset_key_event", key_event, 0);
      check("midreset_frame_error", frame_error, 0);
      reset = 1'b0;
      m_key = 0; m_ext = 1'b0; m_brk = 1'b0;
      tick(TO + 20);
      check("midreset_errors", err_cnt, m_err);
      frame(8'h1C);

      // Randomized key activity.
      last_k = 0;
      for (int a = 0; a < 25; a++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            frame(8'($urandom_range(0, 255)));
         end else if (r == 1) begin
            bp = 1'($urandom_range(0, 1));
            bad_frame(8'($urandom_range(0, 255)), bp);
         end else begin
            brk = ($urandom_range(0, 2) == 0);
            k   = brk && ($urandom_range(0, 1) == 0) ? last_k : $urandom_range(0, 61);
            pick_key(k, e, code);
            if (e)   frame(8'hE0);
            if (brk) frame(8'hF0);
            frame(code);
            if (!brk) last_k = k;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Receives PS/2 scan-code set 2 frames from an external keyboard and translates them into the Hack keyboard keycode presented to hack_soc's keycode input.
- Replaces the button-driven test keyboard in the FPGA top level.
- Runs in the clk domain (25.125 MHz). ps2_clk and ps2_data are asynchronous open-collector inputs.

Parameters:
- FILTER_LEN, 8: number of consecutive identical synchronized samples needed before ps2_clk changes its filtered level.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered ps2_clk falling edge, mid-frame, before the frame is aborted (about 2 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- ps2_clk  in  1  raw PS/2 clock line
- ps2_data  in  1  raw PS/2 data line
- keycode  out  8  Hack keycode of the key currently held; 0 when no key is held
- key_event  out  1  one-cycle pulse whenever keycode changes value
- frame_error  out  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
- Input conditioning:
  - Two-flop synchronizer on ps2_clk and on ps2_data.
  - ps2_clk then passes through a FILTER_LEN-sample stability filter; the filtered level resets to 1.
  - A filtered 1->0 transition is a fall event; synchronized ps2_data is sampled on that same cycle.
- Frame FSM states:
  - IDLE: on fall with data=0 -> DATA, bit count 0. On fall with data=1 -> stay in IDLE and pulse frame_error (bad start bit).
  - DATA: 8 falls, shifting bits in LSB first -> PARITY.
  - PARITY: on fall, latch the parity bit -> STOP.
  - STOP: on fall, require data=1 and odd parity over data+parity bits. If both hold, emit an internal byte_valid with the byte for 1 cycle; otherwise pulse frame_error, no byte. Both cases -> IDLE.
- Timeout:
  - A counter resets on every fall; it is held at 0 in IDLE.
  - Reaching TIMEOUT_CYCLES in any non-IDLE state -> IDLE, frame_error pulse, partial byte discarded.
- Decoder, acting on byte_valid:
  - Flags: ext (E0 seen) and brk (F0 seen).
  - Byte E0 sets ext. Byte F0 sets brk. Neither changes keycode.
  - Any other byte is translated using ext, then ext and brk are cleared.
  - Make code (brk=0) with a nonzero translation: keycode <= translation.
  - Break code (brk=1): keycode <= 0 only if the translation equals the current keycode; otherwise no change.
  - Unmapped codes translate to 0 and are ignored entirely, including their break codes.
  - key_event pulses on the cycle keycode changes. A repeat make of the same key produces no pulse.
- Translation table, non-extended:
  - Letters A-Z map to 65-90 with no shift handling. Examples: 1C->65 (A), 32->66 (B), 1A->90 (Z).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to 48-57.
  - 29->32 (space), 5A->128 (newline), 66->129 (backspace), 76->140 (esc).
  - F1-F12 (05,06,04,0C,03,0B,83,0A,01,09,78,07) map to 141-152.
- Translation table, extended (E0 prefix):
  - 6B->130 left, 75->131 up, 74->132 right, 72->133 down.
  - 6C->134 home, 69->135 end, 7D->136 pgup, 7A->137 pgdn.
  - 70->138 insert, 71->139 delete.
- Boundary cases:
  - byte_valid and a timeout can never coincide, because a valid byte returns the FSM to IDLE.
  - E0 followed by F0 sets both flags, in either order.
  - A frame error does not clear ext or brk.
- Reset:
  - keycode=0, key_event=0, frame_error=0.
  - FSM in IDLE, flags cleared, filter levels at 1, timeout counter 0.
  - Reset mid-frame discards the partial frame silently, with no frame_error.
- Latency: keycode updates 1 cycle after the stop-bit fall event is detected.

Test Plan:
- Make frame 0x1C (PS/2 clock period 80 us, FILTER_LEN=8) -> keycode=65 one cycle after the stop fall; key_event pulses once; frame_error stays 0.
- Sequence 1C, F0 1C -> keycode 65, then 0; key_event pulses twice. Sequence 1C, F0 32 -> keycode stays 65.
- Sequence E0 75, then E0 F0 75 -> keycode 131, then 0. Plain 75 with no E0 -> ignored, keycode unchanged.
- Frame 0x1C with even parity, and a separate frame with stop=0 -> frame_error pulses once for each; keycode stays 0. A following good 0x29 frame -> keycode=32.
- Stop the clock after 4 data bits -> frame_error exactly TIMEOUT_CYCLES after the last fall. A following good 0x5A frame -> keycode=128.
- 3-cycle glitch pulses on ps2_clk -> no fall events. Reset asserted mid-frame -> all outputs 0, no frame_error. A following clean frame decodes correctly.
